// File: rtl/bsg_fsb_node_ls_ctrl.sv
// Power-domain sequencer for one switchable FSB node.
// Owns the node supply switch, the level-shifter/isolation enable and the node-domain reset.
// In-flight traffic is drained before isolating, and node reset is released only after
// isolation has been lifted on a stable supply.
//
// Ports:
//   clk_i, reset_i     always-on clock, synchronous active-high reset
//   pwr_on_req_i       level request to power the node up
//   pwr_off_req_i      level request to power the node down (wins over on-request in ON)
//   pwr_good_i         node supply stable
//   n2f_v_i, f2n_v_i   boundary valids, observed on the FSB side
//   pwr_sw_en_o        node power switch enable
//   en_ls_o            level-shifter enable (0 = isolated)
//   node_reset_o       node-domain reset, active-high
//   on_o               node powered, unisolated and out of reset
//   busy_o             transition in progress
//   timeout_o          sticky: drain timed out and isolation was forced
//   fault_o            sticky: supply dropped while the node was live
module bsg_fsb_node_ls_ctrl #(
  parameter int unsigned reset_cycles_p  = 8,
  parameter int unsigned idle_cycles_p   = 4,
  parameter int unsigned drain_timeout_p = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pwr_on_req_i,
  input  logic pwr_off_req_i,
  input  logic pwr_good_i,
  input  logic n2f_v_i,
  input  logic f2n_v_i,
  output logic pwr_sw_en_o,
  output logic en_ls_o,
  output logic node_reset_o,
  output logic on_o,
  output logic busy_o,
  output logic timeout_o,
  output logic fault_o
);

  localparam int unsigned RstW  = $clog2(reset_cycles_p) + 1;
  localparam int unsigned IdleW = $clog2(idle_cycles_p) + 1;
  localparam int unsigned ToW   = $clog2(drain_timeout_p) + 1;

  localparam logic [RstW-1:0]  RstMax  = RstW'(reset_cycles_p);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(idle_cycles_p);
  localparam logic [ToW-1:0]   ToMax   = ToW'(drain_timeout_p);

  typedef enum logic [2:0] {
    StOff,
    StPwrUp,
    StRelIso,
    StOn,
    StDrain,
    StIsolate,
    StPwrDn
  } state_e;

  state_e           state_q, state_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic             timeout_set, fault_set;

  logic sw_q, sw_d;
  logic en_q, en_d;
  logic nrst_q, nrst_d;
  logic on_q, on_d;
  logic busy_q, busy_d;
  logic timeout_q, fault_q;

  logic any_v;
  assign any_v = n2f_v_i | f2n_v_i;

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    to_cnt_d    = to_cnt_q;
    timeout_set = 1'b0;
    fault_set   = 1'b0;

    unique case (state_q)
      StOff: begin
        if (pwr_on_req_i) state_d = StPwrUp;
      end
      StPwrUp: begin
        if (pwr_good_i) begin
          state_d   = StRelIso;
          rst_cnt_d = '0;
        end
      end
      StRelIso: begin
        if (!pwr_good_i) begin
          state_d   = StIsolate;
          fault_set = 1'b1;
        end else if (rst_cnt_q == RstMax) begin
          state_d = StOn;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StOn: begin
        if (!pwr_good_i) begin
          state_d   = StIsolate;
          fault_set = 1'b1;
        end else if (pwr_off_req_i) begin
          state_d    = StDrain;
          idle_cnt_d = '0;
          to_cnt_d   = '0;
        end
      end
      StDrain: begin
        if (!pwr_good_i) begin
          state_d   = StIsolate;
          fault_set = 1'b1;
        end else if (idle_cnt_q == IdleMax) begin
          state_d = StIsolate;
        end else if (to_cnt_q == ToMax) begin
          // Traffic never settled; isolate anyway rather than hold the node forever.
          state_d     = StIsolate;
          timeout_set = 1'b1;
        end else if (!pwr_off_req_i) begin
          state_d    = StOn;
          idle_cnt_d = '0;
          to_cnt_d   = '0;
        end else begin
          if (any_v) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if (to_cnt_q != ToMax) to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StIsolate: begin
        state_d = StPwrDn;
      end
      StPwrDn: begin
        if (!pwr_good_i) state_d = StOff;
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with state_q.
  always_comb begin
    sw_d   = 1'b0;
    en_d   = 1'b0;
    nrst_d = 1'b1;
    on_d   = 1'b0;
    busy_d = 1'b1;
    unique case (state_d)
      StOff: begin
        busy_d = 1'b0;
      end
      StPwrUp: begin
        sw_d = 1'b1;
      end
      StRelIso: begin
        sw_d = 1'b1;
        en_d = 1'b1;
      end
      StOn: begin
        sw_d   = 1'b1;
        en_d   = 1'b1;
        nrst_d = 1'b0;
        on_d   = 1'b1;
        busy_d = 1'b0;
      end
      StDrain: begin
        sw_d   = 1'b1;
        en_d   = 1'b1;
        nrst_d = 1'b0;
      end
      StIsolate: begin
        sw_d = 1'b1;
      end
      StPwrDn: begin
        sw_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StOff;
      rst_cnt_q  <= '0;
      idle_cnt_q <= '0;
      to_cnt_q   <= '0;
      sw_q       <= 1'b0;
      en_q       <= 1'b0;
      nrst_q     <= 1'b1;
      on_q       <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      to_cnt_q   <= to_cnt_d;
      sw_q       <= sw_d;
      en_q       <= en_d;
      nrst_q     <= nrst_d;
      on_q       <= on_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_q | timeout_set;
      fault_q    <= fault_q | fault_set;
    end
  end

  assign pwr_sw_en_o  = sw_q;
  assign en_ls_o      = en_q;
  assign node_reset_o = nrst_q;
  assign on_o         = on_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_bsg_fsb_node_ls_ctrl.sv
// Self-checking bench for bsg_fsb_node_ls_ctrl.
// Expected drain outcomes come from a per-cycle traffic table scanned for the first idle run
// or the drain time limit; other expectations are fixed latencies and output levels.
module tb_bsg_fsb_node_ls_ctrl;

  localparam int RST  = 8;
  localparam int IDLE = 4;
  localparam int TO   = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic on_req = 1'b0;
  logic off_req = 1'b0;
  logic pg = 1'b0;
  logic n2f_v = 1'b0;
  logic f2n_v = 1'b0;
  logic sw, en, nrst, on, busy, tmo, flt;
  logic [6:0] outs;

  int errors = 0;
  int checks = 0;
  bit exp_to = 1'b0;
  bit exp_flt = 1'b0;

  assign outs = {sw, en, nrst, on, busy, tmo, flt};

  bsg_fsb_node_ls_ctrl #(
    .reset_cycles_p (RST),
    .idle_cycles_p  (IDLE),
    .drain_timeout_p(TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pwr_on_req_i (on_req),
    .pwr_off_req_i(off_req),
    .pwr_good_i   (pg),
    .n2f_v_i      (n2f_v),
    .f2n_v_i      (f2n_v),
    .pwr_sw_en_o  (sw),
    .en_ls_o      (en),
    .node_reset_o (nrst),
    .on_o         (on),
    .busy_o       (busy),
    .timeout_o    (tmo),
    .fault_o      (flt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Advance one edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Power-up stimulus only; leaves the node in ON with on_req low.
  task automatic bring_up();
    on_req = 1'b1;
    pg = 1'b0;
    step();
    pg = 1'b1;
    step();
    repeat (RST + 1) step();
    on_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (outs !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected %b", outs, 7'b0010000);
    end
    reset = 1'b0;
    exp_to = 1'b0;
    exp_flt = 1'b0;
    step();
    checks++;
    if (outs !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_idle_off: got %b expected %b", outs, 7'b0010000);
    end
  endtask

  task automatic test_power_up();
    int d;
    int n;
    on_req = 1'b1;
    pg = 1'b0;
    step();
    checks++;
    if (outs !== 7'b1010100) begin
      errors++;
      $display("FAIL pwr_up_outs: got %b expected %b", outs, 7'b1010100);
    end
    d = int'($urandom_range(1, 5));
    for (int i = 0; i < d; i++) begin
      step();
      checks++;
      if (en !== 1'b0 || sw !== 1'b1) begin
        errors++;
        $display("FAIL pwr_up_wait: got en=%b sw=%b expected en=0 sw=1", en, sw);
      end
    end
    pg = 1'b1;
    step();
    checks++;
    if (outs !== 7'b1110100) begin
      errors++;
      $display("FAIL rel_iso_outs: got %b expected %b", outs, 7'b1110100);
    end
    n = 0;
    while (nrst === 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != RST + 1) begin
      errors++;
      $display("FAIL reset_release_latency: got %0d expected %0d", n, RST + 1);
    end
    checks++;
    if (outs !== 7'b1101000) begin
      errors++;
      $display("FAIL on_outs: got %b expected %b", outs, 7'b1101000);
    end
    on_req = 1'b0;
  endtask

  task automatic test_clean_power_down();
    int n;
    off_req = 1'b1;
    n = 0;
    while (en === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != IDLE + 2) begin
      errors++;
      $display("FAIL clean_iso_latency: got %0d expected %0d", n, IDLE + 2);
    end
    checks++;
    if (sw !== 1'b1 || nrst !== 1'b1) begin
      errors++;
      $display("FAIL isolate_outs: got sw=%b nrst=%b expected sw=1 nrst=1", sw, nrst);
    end
    step();
    checks++;
    if (sw !== 1'b0) begin
      errors++;
      $display("FAIL switch_off_latency: got sw=%b expected 0", sw);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pwr_dn_wait: got busy=%b expected 1", busy);
    end
    pg = 1'b0;
    step();
    checks++;
    if (outs !== {5'b00100, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL clean_off_outs: got %b expected %b", outs, {5'b00100, exp_to, exp_flt});
    end
    off_req = 1'b0;
  endtask

  task automatic test_drain_traffic(input int density, input bit toggle);
    bit n2f_a[0:TO+4];
    bit f2n_a[0:TO+4];
    int run;
    int iso_j;
    int got;
    bit force_exp;
    bring_up();
    checks++;
    if (on !== 1'b1) begin
      errors++;
      $display("FAIL drain_pre_on: got on=%b expected 1", on);
    end
    for (int j = 0; j <= TO + 4; j++) begin
      if (toggle) begin
        n2f_a[j] = 1'b0;
        f2n_a[j] = ((j / 3) % 2) == 0;
      end else begin
        n2f_a[j] = int'($urandom_range(0, 99)) < density;
        f2n_a[j] = int'($urandom_range(0, 99)) < density;
      end
    end
    // Reference: cycle j of DRAIN isolates once IDLE idle cycles have run back to back,
    // or once the drain has lasted TO cycles (idle completion takes precedence).
    run = 0;
    iso_j = 0;
    force_exp = 1'b0;
    for (int j = 1; j <= TO + 1; j++) begin
      if (run >= IDLE) begin
        iso_j = j;
        force_exp = 1'b0;
        break;
      end
      if (j - 1 >= TO) begin
        iso_j = j;
        force_exp = 1'b1;
        break;
      end
      run = (n2f_a[j] || f2n_a[j]) ? 0 : run + 1;
    end
    off_req = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || on !== 1'b0 || en !== 1'b1) begin
      errors++;
      $display("FAIL drain_entry: got busy=%b on=%b en=%b expected 1 0 1", busy, on, en);
    end
    got = 0;
    for (int j = 1; j <= TO + 4; j++) begin
      n2f_v = n2f_a[j];
      f2n_v = f2n_a[j];
      step();
      if (en !== 1'b1) begin
        got = j;
        break;
      end
    end
    n2f_v = 1'b0;
    f2n_v = 1'b0;
    checks++;
    if (got != iso_j) begin
      errors++;
      $display("FAIL drain_iso_cycle: got %0d expected %0d (density %0d)", got, iso_j, density);
    end
    exp_to = exp_to | force_exp;
    checks++;
    if (tmo !== exp_to) begin
      errors++;
      $display("FAIL drain_timeout_flag: got %b expected %b", tmo, exp_to);
    end
    step();
    pg = 1'b0;
    step();
    checks++;
    if (outs !== {5'b00100, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL drain_off_outs: got %b expected %b", outs, {5'b00100, exp_to, exp_flt});
    end
    off_req = 1'b0;
  endtask

  task automatic test_abort_priority();
    int n;
    bring_up();
    off_req = 1'b1;
    step();
    checks++;
    if (on !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_drain_entry: got on=%b busy=%b expected 0 1", on, busy);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (en !== 1'b1) begin
        errors++;
        $display("FAIL abort_en_held: got en=%b expected 1", en);
      end
    end
    off_req = 1'b0;
    step();
    checks++;
    if (outs !== {5'b11010, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL abort_back_on: got %b expected %b", outs, {5'b11010, exp_to, exp_flt});
    end
    // Both requests high in ON: off wins.
    on_req = 1'b1;
    off_req = 1'b1;
    step();
    checks++;
    if (on !== 1'b0 || busy !== 1'b1 || en !== 1'b1) begin
      errors++;
      $display("FAIL both_in_on: got on=%b busy=%b en=%b expected 0 1 1", on, busy, en);
    end
    n = 0;
    while (en === 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != IDLE + 1) begin
      errors++;
      $display("FAIL both_iso_latency: got %0d expected %0d", n, IDLE + 1);
    end
    step();
    pg = 1'b0;
    step();
    checks++;
    if (outs !== {5'b00100, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL both_off_outs: got %b expected %b", outs, {5'b00100, exp_to, exp_flt});
    end
    // Both requests high in OFF: on wins.
    step();
    checks++;
    if (sw !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_in_off: got sw=%b busy=%b expected 1 1", sw, busy);
    end
    off_req = 1'b0;
    pg = 1'b1;
    step();
    repeat (RST + 1) step();
    on_req = 1'b0;
    checks++;
    if (on !== 1'b1) begin
      errors++;
      $display("FAIL both_repower_on: got on=%b expected 1", on);
    end
  endtask

  task automatic test_brown_out();
    pg = 1'b0;
    step();
    exp_flt = 1'b1;
    checks++;
    if (outs !== {5'b10101, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL brown_out_isolate: got %b expected %b", outs, {5'b10101, exp_to, exp_flt});
    end
    step();
    checks++;
    if (sw !== 1'b0 || en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL brown_out_pwr_dn: got sw=%b en=%b busy=%b expected 0 0 1", sw, en, busy);
    end
    step();
    checks++;
    if (outs !== {5'b00100, exp_to, exp_flt}) begin
      errors++;
      $display("FAIL brown_out_off: got %b expected %b", outs, {5'b00100, exp_to, exp_flt});
    end
  endtask

  task automatic test_reset_mid();
    on_req = 1'b1;
    pg = 1'b0;
    step();
    pg = 1'b1;
    step();
    step();
    checks++;
    if (en !== 1'b1 || nrst !== 1'b1) begin
      errors++;
      $display("FAIL mid_rel_iso: got en=%b nrst=%b expected 1 1", en, nrst);
    end
    reset = 1'b1;
    step();
    exp_to = 1'b0;
    exp_flt = 1'b0;
    checks++;
    if (outs !== 7'b0010000) begin
      errors++;
      $display("FAIL mid_reset_outs: got %b expected %b", outs, 7'b0010000);
    end
    reset = 1'b0;
    on_req = 1'b0;
    pg = 1'b0;
    step();
    checks++;
    if (outs !== 7'b0010000) begin
      errors++;
      $display("FAIL post_reset_off: got %b expected %b", outs, 7'b0010000);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_clean_power_down();
    test_drain_traffic(0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      test_drain_traffic(int'($urandom_range(5, 85)), 1'b0);
    end
    test_abort_priority();
    test_brown_out();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
